// File: rtl/cache_data_pkg.sv
//------------------------------------------------------------------------------
// Module      : cache_data_pkg
// Description : Shared width helpers and read-format encoding for the cache
//               data array.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_data_pkg;

   typedef enum logic {
      RD_FMT_WORD  = 1'b0,
      RD_FMT_ALIGN = 1'b1
   } rd_fmt_e;

   function automatic int idx_width(input int num_sets);
      return (num_sets > 1) ? $clog2(num_sets) : 1;
   endfunction

   function automatic int off_width(input int line_bits);
      return $clog2(line_bits / 8);
   endfunction

   function automatic int word_bytes(input int word_bits);
      return word_bits / 8;
   endfunction

   // Kept at least one bit wide so single-word lines still have a legal index port.
   function automatic int word_idx_width(input int line_bits, input int word_bits);
      return ((line_bits / word_bits) > 1) ? $clog2(line_bits / word_bits) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/line_byte_merge.sv
//------------------------------------------------------------------------------
// Module      : line_byte_merge
// Description : Combinational byte-enabled merge of one word into a cache line.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_byte_merge
   import cache_data_pkg::*;
#(
   parameter int  LINE_BITS  = 256,
   parameter int  WORD_BITS  = 32,
   localparam int WORD_BYTES = word_bytes(WORD_BITS),
   localparam int NUM_WORDS  = LINE_BITS / WORD_BITS,
   localparam int WIDX_W     = word_idx_width(LINE_BITS, WORD_BITS)
)(
   input  logic [LINE_BITS-1:0]  line_in,
   input  logic [WIDX_W-1:0]     word_idx,
   input  logic [WORD_BYTES-1:0] mask,
   input  logic [WORD_BITS-1:0]  wdata,
   output logic [LINE_BITS-1:0]  line_out
);

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      for (genvar b = 0; b < WORD_BYTES; b++) begin : g_byte
         localparam int LSB = w * WORD_BITS + 8 * b;
         assign line_out[LSB +: 8] = ((word_idx == WIDX_W'(w)) && mask[b])
                                     ? wdata[8*b +: 8] : line_in[LSB +: 8];
      end
   end

endmodule

`default_nettype wire

// File: rtl/cache_data_array.sv
//------------------------------------------------------------------------------
// Module      : cache_data_array
// Description : Registered multi-set cache data store with CPU word access,
//               memory line fill and writeback line/dirty readout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_data_array
   import cache_data_pkg::*;
#(
   parameter int  NUM_SETS   = 32,
   parameter int  LINE_BITS  = 256,
   parameter int  WORD_BITS  = 32,
   parameter int  ALIGN_READ = 1,
   localparam int IDX_W      = idx_width(NUM_SETS),
   localparam int OFF_W      = off_width(LINE_BITS),
   localparam int WORD_BYTES = word_bytes(WORD_BITS)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_read,
   input  logic                  cpu_write,
   input  logic [IDX_W-1:0]      cpu_set,
   input  logic [OFF_W-1:0]      cpu_offset,
   input  logic [WORD_BYTES-1:0] cpu_byte_enable,
   input  logic [WORD_BITS-1:0]  cpu_wdata,
   output logic [WORD_BITS-1:0]  cpu_rdata,
   output logic                  cpu_resp,
   input  logic                  fill_we,
   input  logic [IDX_W-1:0]      fill_set,
   input  logic [LINE_BITS-1:0]  fill_data,
   input  logic                  wb_req,
   input  logic [IDX_W-1:0]      wb_set,
   output logic [LINE_BITS-1:0]  wb_data,
   output logic                  wb_dirty,
   output logic                  wb_resp
);

   localparam int      WIDX_W   = word_idx_width(LINE_BITS, WORD_BITS);
   localparam int      BSEL_W   = $clog2(WORD_BYTES);
   localparam rd_fmt_e READ_FMT = (ALIGN_READ != 0) ? RD_FMT_ALIGN : RD_FMT_WORD;

   logic [LINE_BITS-1:0]  mem_q [NUM_SETS];
   logic [LINE_BITS-1:0]  mem_d [NUM_SETS];
   logic [NUM_SETS-1:0]   dirty_q, dirty_d;
   logic [WORD_BITS-1:0]  cpu_rdata_q, cpu_rdata_d;
   logic                  cpu_resp_q, cpu_resp_d;
   logic [LINE_BITS-1:0]  wb_data_q, wb_data_d;
   logic                  wb_dirty_q, wb_dirty_d;
   logic                  wb_resp_q, wb_resp_d;

   logic [WIDX_W-1:0]     w_word_idx;
   logic [OFF_W-1:0]      w_byte_sel;
   logic [WORD_BYTES-1:0] w_mask;
   logic [LINE_BITS-1:0]  w_cpu_base;
   logic [LINE_BITS-1:0]  w_merged;
   logic [WORD_BITS-1:0]  w_word;
   logic [WORD_BITS-1:0]  w_word_fmt;

   assign w_word_idx = WIDX_W'(cpu_offset >> BSEL_W);
   assign w_byte_sel = cpu_offset & OFF_W'(WORD_BYTES - 1);
   assign w_mask     = cpu_write ? cpu_byte_enable : '0;

   // A same-cycle fill lands first, so both the merge and the read see fill data.
   assign w_cpu_base = (fill_we && (fill_set == cpu_set)) ? fill_data : mem_q[cpu_set];

   line_byte_merge #(
      .LINE_BITS (LINE_BITS),
      .WORD_BITS (WORD_BITS)
   ) u_merge (
      .line_in  (w_cpu_base),
      .word_idx (w_word_idx),
      .mask     (w_mask),
      .wdata    (cpu_wdata),
      .line_out (w_merged)
   );

   assign w_word = w_merged[w_word_idx*WORD_BITS +: WORD_BITS];

   always_comb begin
      w_word_fmt = w_word;
      if (READ_FMT == RD_FMT_ALIGN) begin
         w_word_fmt = w_word >> {w_byte_sel, 3'b000};
      end
   end

   always_comb begin
      mem_d   = mem_q;
      dirty_d = dirty_q;
      if (!rst) begin
         if (fill_we) begin
            mem_d[fill_set]   = fill_data;
            dirty_d[fill_set] = 1'b0;
         end
         if (cpu_write) begin
            mem_d[cpu_set] = w_merged;
            if (|cpu_byte_enable) begin
               dirty_d[cpu_set] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cpu_resp_d  = cpu_read | cpu_write;
      cpu_rdata_d = cpu_resp_d ? w_word_fmt : cpu_rdata_q;
      wb_resp_d   = wb_req;
      wb_data_d   = wb_req ? mem_d[wb_set] : wb_data_q;
      wb_dirty_d  = wb_req ? dirty_d[wb_set] : wb_dirty_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dirty_q     <= '0;
         cpu_rdata_q <= '0;
         cpu_resp_q  <= 1'b0;
         wb_data_q   <= '0;
         wb_dirty_q  <= 1'b0;
         wb_resp_q   <= 1'b0;
      end else begin
         dirty_q     <= dirty_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_resp_q  <= cpu_resp_d;
         wb_data_q   <= wb_data_d;
         wb_dirty_q  <= wb_dirty_d;
         wb_resp_q   <= wb_resp_d;
      end
   end

   // Line storage is deliberately not reset; mem_d already holds during reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Masking by rst drops a response that would land in a reset cycle.
   assign cpu_rdata = rst ? '0 : cpu_rdata_q;
   assign cpu_resp  = cpu_resp_q & ~rst;
   assign wb_data   = rst ? '0 : wb_data_q;
   assign wb_dirty  = wb_dirty_q & ~rst;
   assign wb_resp   = wb_resp_q & ~rst;

endmodule

`default_nettype wire
